// File: rtl/div3_share_arb.sv
// div3_share_arb: round-robin arbiter plus two-register pipeline that shares a
// single combinational 16-bit divide-by-3 datapath among NUM_REQ requesters.
// Stage 1 captures the granted dividend and requester id and feeds the shared
// divider. Stage 2 captures the quotient (and optionally the remainder) with
// the id. Flow control is valid/ready on both sides, and nothing is dropped.
// Optional feature: define DIV3_SHARE_REM_EN to add the registered resp_rem
// output (x mod 3). Without the macro the port and its logic are absent.

// Standalone combinational divide-by-3: X[16:1] -> Q[15:1].
module div_16_3_stand (
  input  logic [16:1] x,
  output logic [15:1] q
);

  // MSB-first long division by 3. The partial remainder is always in 0..2, so
  // each step needs only a compare against 3. The top dividend bit alone is
  // below 3, so its quotient bit is always 0 and the loop starts one bit lower.
  function automatic logic [14:0] div3_quot(input logic [15:0] dividend);
    logic [1:0]  r;
    logic [2:0]  t;
    logic [14:0] quot;
    r    = {1'b0, dividend[15]};
    quot = 15'd0;
    for (int i = 14; i >= 0; i--) begin
      t = {r, dividend[i]};
      if (t >= 3'd3) begin
        quot[i] = 1'b1;
        r       = 2'(t - 3'd3);
      end else begin
        quot[i] = 1'b0;
        r       = t[1:0];
      end
    end
    return quot;
  endfunction

  assign q = div3_quot(x);

endmodule

// Invariant checker for the arbiter handshake.
module div3_share_arb_chk #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input logic               clk,
  input logic               rst_n,
  input logic [NUM_REQ-1:0] req_valid,
  input logic [NUM_REQ-1:0] req_ready,
  input logic               resp_valid,
  input logic [ID_W-1:0]    resp_id
);

  // At most one requester is granted in any cycle.
  a_grant_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(req_ready));

  // A grant is only issued to a requester that is asking.
  a_grant_needs_valid : assert property (@(posedge clk) disable iff (!rst_n)
    ((req_ready & ~req_valid) == '0));

  // A presented result always carries a legal requester index.
  a_resp_id_range : assert property (@(posedge clk) disable iff (!rst_n)
    resp_valid |-> (32'(resp_id) < NUM_REQ));

endmodule

module div3_share_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*16-1:0] req_x,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [ID_W-1:0]       resp_id,
  output logic [14:0]           resp_q
`ifdef DIV3_SHARE_REM_EN
  ,
  output logic [1:0]            resp_rem
`endif
);

  logic [ID_W-1:0] rr_ptr_r;
  logic            s1_valid_r;
  logic [15:0]     s1_x_r;
  logic [ID_W-1:0] s1_id_r;

  logic            adv1_s;
  logic            adv2_s;
  logic            grant_found_s;
  logic [ID_W-1:0] grant_idx_s;
  logic [ID_W:0]   cand_s;
  logic [15:0]     sel_x_s;
  logic            xfer_s;
  logic [ID_W-1:0] ptr_next_s;
  logic [14:0]     q_s;
`ifdef DIV3_SHARE_REM_EN
  logic [1:0]      rem_s;
`endif

  // Stage 2 moves whenever its slot is empty or being drained this cycle;
  // stage 1 moves whenever it is empty or stage 2 is moving.
  assign adv2_s = !resp_valid || resp_ready;
  assign adv1_s = !s1_valid_r || adv2_s;
  assign xfer_s = adv1_s && grant_found_s;

  // Round-robin search: first asserted request at or after rr_ptr, wrapping.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    cand_s        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s = {1'b0, rr_ptr_r} + (ID_W+1)'(k);
      if (cand_s >= (ID_W+1)'(NUM_REQ)) begin
        cand_s = cand_s - (ID_W+1)'(NUM_REQ);
      end else begin
        cand_s = cand_s;
      end
      if (!grant_found_s && req_valid[cand_s[ID_W-1:0]]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = cand_s[ID_W-1:0];
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Select the granted dividend and drive the one-hot grant (held low in reset).
  always_comb begin
    sel_x_s   = 16'd0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx_s == ID_W'(i)) begin
        sel_x_s      = req_x[16*i +: 16];
        req_ready[i] = rst_n && xfer_s;
      end else begin
        req_ready[i] = 1'b0;
      end
    end
  end

  // Pointer advances to the index after the one just served.
  always_comb begin
    if (grant_idx_s == ID_W'(NUM_REQ - 1)) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = grant_idx_s + ID_W'(1);
    end
  end

  // Round-robin pointer moves only on an actual transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_r <= '0;
    end else if (xfer_s) begin
      rr_ptr_r <= ptr_next_s;
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  // Stage 1: capture the granted request, or a bubble when nobody is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_x_r     <= 16'd0;
      s1_id_r    <= '0;
    end else if (adv1_s) begin
      s1_valid_r <= grant_found_s;
      if (grant_found_s) begin
        s1_x_r  <= sel_x_s;
        s1_id_r <= grant_idx_s;
      end else begin
        s1_x_r  <= s1_x_r;
        s1_id_r <= s1_id_r;
      end
    end else begin
      s1_valid_r <= s1_valid_r;
      s1_x_r     <= s1_x_r;
      s1_id_r    <= s1_id_r;
    end
  end

  div_16_3_stand u_div (
    .x (s1_x_r),
    .q (q_s)
  );

`ifdef DIV3_SHARE_REM_EN
  // Remainder recovered from the quotient in the same stage: x - 3*q.
  assign rem_s = 2'(s1_x_r - ({q_s, 1'b0} + {1'b0, q_s}));
`endif

  // Stage 2: result register, frozen while the consumer applies backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_q     <= 15'd0;
      resp_id    <= '0;
`ifdef DIV3_SHARE_REM_EN
      resp_rem   <= 2'd0;
`endif
    end else if (adv2_s) begin
      resp_valid <= s1_valid_r;
      resp_q     <= q_s;
      resp_id    <= s1_id_r;
`ifdef DIV3_SHARE_REM_EN
      resp_rem   <= rem_s;
`endif
    end else begin
      resp_valid <= resp_valid;
      resp_q     <= resp_q;
      resp_id    <= resp_id;
`ifdef DIV3_SHARE_REM_EN
      resp_rem   <= resp_rem;
`endif
    end
  end

  div3_share_arb_chk #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_chk (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_id    (resp_id)
  );

endmodule

// File: tb/tb_div3_share_arb.sv
// Bench for div3_share_arb: directed phases followed by random traffic, all
// checked every cycle against a transaction-level reference model (a queue of
// expected results, each stamped with the cycle of its transfer).
module tb_div3_share_arb;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*16-1:0] req_x;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [ID_W-1:0]       resp_id;
  logic [14:0]           resp_q;
`ifdef DIV3_SHARE_REM_EN
  logic [1:0]            resp_rem;
`endif

  div3_share_arb #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
`ifdef DIV3_SHARE_REM_EN
    .resp_rem   (resp_rem),
`endif
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_x      (req_x),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_q     (resp_q)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int q;
    int rem;
    int t;
  } exp_t;

  exp_t        exp_q[$];
  int          tests_run    = 0;
  int          tests_failed = 0;
  int          cyc          = 0;
  int          m_ptr        = 0;
  bit          want[NUM_REQ];
  logic [15:0] xv[NUM_REQ];
  int          g;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [15:0] rand_x();
    case ($urandom_range(0, 7))
      0:       return 16'd0;
      1:       return 16'd65535;
      2:       return 16'd65534;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i]       = want[i];
      req_x[16*i +: 16]  = xv[i];
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check_eq({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    check_eq({tag, "_resp_id"}, 32'(resp_id), 32'd0);
    check_eq({tag, "_resp_q"}, 32'(resp_q), 32'd0);
`ifdef DIV3_SHARE_REM_EN
    check_eq({tag, "_resp_rem"}, 32'(resp_rem), 32'd0);
`endif
  endtask

  // One cycle: compare against the model with the currently driven inputs,
  // advance the model, then move to the next falling edge.
  task automatic tick(output int gnt);
    int                 n;
    bit                 rv;
    bit                 s1v;
    bit                 adv1;
    int                 idx;
    int                 x;
    logic [NUM_REQ-1:0] exp_rdy;
    #1;
    n = exp_q.size();
    // A result is visible two cycles after its transfer, oldest first.
    rv   = (n > 0) && (cyc >= exp_q[0].t + 2);
    // The front slot is busy if two results are in flight, or the only one
    // was transferred in the previous cycle.
    s1v  = (n == 2) || ((n == 1) && (exp_q[0].t == cyc - 1));
    adv1 = !s1v || !rv || resp_ready;
    gnt  = -1;
    exp_rdy = '0;
    if (adv1) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = (m_ptr + k) % NUM_REQ;
        if (gnt < 0 && req_valid[idx]) gnt = idx;
      end
    end
    if (gnt >= 0) exp_rdy[gnt] = 1'b1;
    check_eq("req_ready", 32'(req_ready), 32'(exp_rdy));
    check_eq("resp_valid", 32'(resp_valid), 32'(rv));
    if (rv) begin
      check_eq("resp_id", 32'(resp_id), 32'(exp_q[0].id));
      check_eq("resp_q", 32'(resp_q), 32'(exp_q[0].q));
`ifdef DIV3_SHARE_REM_EN
      check_eq("resp_rem", 32'(resp_rem), 32'(exp_q[0].rem));
`endif
    end
    if (rv && resp_ready) void'(exp_q.pop_front());
    if (gnt >= 0) begin
      x = int'(req_x[16*gnt +: 16]);
      exp_q.push_back('{id: gnt, q: x / 3, rem: x % 3, t: cyc});
      m_ptr = (gnt + 1) % NUM_REQ;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_cycle(input bit rdy);
    int gg;
    resp_ready = rdy;
    drive();
    tick(gg);
    if (gg >= 0) want[gg] = 1'b0;
    g = gg;
  endtask

  task automatic reset_pulse();
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    check_all_zero("midrst_hold");
    rst_n = 1'b1;
    exp_q.delete();
    m_ptr = 0;
    cyc++;
  endtask

  initial begin
    rst_n      = 1'b0;
    resp_ready = 1'b1;
    req_valid  = '1;
    req_x      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      want[i] = 1'b0;
      xv[i]   = 16'd0;
    end
    @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;

    // Single request, then the boundary dividends walking the pointer to wrap.
    want[0] = 1'b1; xv[0] = 16'd100;
    for (int c = 0; c < 4; c++) run_cycle(1'b1);
    want[1] = 1'b1; xv[1] = 16'd0;
    for (int c = 0; c < 3; c++) run_cycle(1'b1);
    want[2] = 1'b1; xv[2] = 16'd65534;
    for (int c = 0; c < 3; c++) run_cycle(1'b1);
    want[3] = 1'b1; xv[3] = 16'd65535;
    for (int c = 0; c < 3; c++) run_cycle(1'b1);

    // All four at once from pointer 0.
    for (int i = 0; i < NUM_REQ; i++) begin
      want[i] = 1'b1;
      xv[i]   = 16'(3 * (i + 1));
    end
    for (int c = 0; c < 8; c++) run_cycle(1'b1);

    // Backpressure with both stages full, then drain.
    for (int i = 0; i < NUM_REQ; i++) begin
      want[i] = 1'b1;
      xv[i]   = rand_x();
    end
    for (int c = 0; c < 7; c++) run_cycle(1'b0);
    for (int c = 0; c < 8; c++) run_cycle(1'b1);

    // Two requesters held continuously must alternate.
    for (int c = 0; c < 10; c++) begin
      if (!want[1]) begin want[1] = 1'b1; xv[1] = rand_x(); end
      if (!want[2]) begin want[2] = 1'b1; xv[2] = rand_x(); end
      run_cycle(1'b1);
    end
    want[1] = 1'b0; want[2] = 1'b0;
    for (int c = 0; c < 4; c++) run_cycle(1'b1);

    // Reset with both stages full; nothing stale may appear afterwards.
    for (int i = 0; i < NUM_REQ; i++) begin
      want[i] = 1'b1;
      xv[i]   = rand_x();
    end
    for (int c = 0; c < 4; c++) run_cycle(1'b0);
    reset_pulse();
    for (int i = 0; i < NUM_REQ; i++) want[i] = 1'b0;
    for (int c = 0; c < 5; c++) run_cycle(1'b1);

    // Random traffic, including requesters that withdraw before a grant.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!want[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            want[i] = 1'b1;
            xv[i]   = rand_x();
          end
        end else if ($urandom_range(0, 15) == 0) begin
          want[i] = 1'b0;
        end
      end
      run_cycle($urandom_range(0, 3) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
